// File: rtl/d_cache_pkg.sv
// Shared encodings for the direct-mapped write-through data cache:
// load/store type codes, FSM state encoding and the byte-merge helper.
package d_cache_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [2:0] DATA_CACHE_LOAD_NONE = 3'b000;
  localparam logic [2:0] DATA_CACHE_LOAD_B_S  = 3'b010;
  localparam logic [2:0] DATA_CACHE_LOAD_B_U  = 3'b011;
  localparam logic [2:0] DATA_CACHE_LOAD_H_S  = 3'b100;
  localparam logic [2:0] DATA_CACHE_LOAD_H_U  = 3'b101;
  localparam logic [2:0] DATA_CACHE_LOAD_W    = 3'b110;

  localparam logic [1:0] DATA_CACHE_STORE_NONE = 2'b00;
  localparam logic [1:0] DATA_CACHE_STORE_B    = 2'b01;
  localparam logic [1:0] DATA_CACHE_STORE_H    = 2'b10;
  localparam logic [1:0] DATA_CACHE_STORE_W    = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } d_cache_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/d_cache_load_align.sv
// Combinational byte/halfword select and sign/zero extension of a cached word.
// Misaligned halves and words are silently aligned down.
module d_cache_load_align
  import d_cache_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int D_CACHE_LW_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]       word,
  input  logic [1:0]                  byte_sel,
  input  logic [D_CACHE_LW_WIDTH-1:0] load_type,
  output logic [DATA_WIDTH-1:0]       load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = word[{byte_sel, 3'b000} +: 8];
  assign half_val = word[{byte_sel[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (load_type)
      DATA_CACHE_LOAD_B_S: load_data = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
      DATA_CACHE_LOAD_B_U: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_val};
      DATA_CACHE_LOAD_H_S: load_data = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
      DATA_CACHE_LOAD_H_U: load_data = {{(DATA_WIDTH-16){1'b0}}, half_val};
      DATA_CACHE_LOAD_W:   load_data = word;
      default:             load_data = '0;
    endcase
  end

endmodule

// File: rtl/data_cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache, one word per line.
// state   | meaning
// IDLE    | serve load hits in zero wait states, launch misses and stores
// RD_ADDR | read address offered to L2 until accepted
// RD_DATA | waiting for the fill word, then validate the line
// WR_REQ  | write request offered to L2 until accepted
// WR_WAIT | waiting for the L2 write-complete pulse
module data_cache_dm_wt
  import d_cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int L2_BUS_WIDTH     = 32,
  parameter int D_CACHE_LW_WIDTH = 3,
  parameter int D_CACHE_SW_WIDTH = 2,
  parameter int INDEX_WIDTH      = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ADDRESS_WIDTH-1:0]      DATA_CACHE_READ_ADDRESS,
  input  logic [D_CACHE_LW_WIDTH-1:0]   DATA_CACHE_LOAD,
  input  logic [ADDRESS_WIDTH-1:0]      DATA_CACHE_WRITE_ADDRESS,
  input  logic [DATA_WIDTH-1:0]         DATA_CACHE_WRITE_DATA,
  input  logic [D_CACHE_SW_WIDTH-1:0]   DATA_CACHE_STORE,
  output logic                          DATA_CACHE_READY,
  output logic [DATA_WIDTH-1:0]         DATA_CACHE_READ_DATA,
  input  logic                          WRITE_TO_L2_READY_DATA,
  output logic                          WRITE_TO_L2_VALID_DATA,
  output logic [ADDRESS_WIDTH-3:0]      WRITE_ADDR_TO_L2_DATA,
  output logic [L2_BUS_WIDTH-1:0]       DATA_TO_L2_DATA,
  output logic [L2_BUS_WIDTH/8-1:0]     WRITE_STROBE_TO_L2_DATA,
  output logic                          WRITE_CONTROL_TO_L2_DATA,
  input  logic                          WRITE_COMPLETE_DATA,
  input  logic                          READ_ADDR_TO_L2_READY_DATA,
  output logic                          READ_ADDR_TO_L2_VALID_DATA,
  output logic [ADDRESS_WIDTH-3:0]      READ_ADDR_TO_L2_DATA,
  output logic                          DATA_FROM_L2_READY_DATA,
  input  logic                          DATA_FROM_L2_VALID_DATA,
  input  logic [L2_BUS_WIDTH-1:0]       DATA_FROM_L2_DATA
);

  localparam int LINES       = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH   = ADDRESS_WIDTH - 2 - INDEX_WIDTH;
  localparam int WADDR_WIDTH = ADDRESS_WIDTH - 2;
  localparam int STRB_WIDTH  = L2_BUS_WIDTH / 8;

  d_cache_state_e state_q, state_d;

  logic [LINES-1:0]        valid_q;
  logic [TAG_WIDTH-1:0]    tag_q  [LINES];
  logic [L2_BUS_WIDTH-1:0] data_q [LINES];

  logic [WADDR_WIDTH-1:0]  rd_addr_q, wr_addr_q;
  logic [L2_BUS_WIDTH-1:0] wr_data_q;
  logic [STRB_WIDTH-1:0]   wr_strb_q;
  logic                    done_q;

  logic [INDEX_WIDTH-1:0]  rd_idx, wr_idx, fill_idx;
  logic [TAG_WIDTH-1:0]    rd_tag, wr_tag, fill_tag;
  logic                    rd_hit, wr_hit, load_req, store_req;
  logic                    start_store, start_load, cpu_ready;
  logic [L2_BUS_WIDTH-1:0] st_data;
  logic [STRB_WIDTH-1:0]   st_strb;
  logic [DATA_WIDTH-1:0]   load_data;

  assign rd_idx   = DATA_CACHE_READ_ADDRESS[INDEX_WIDTH+1:2];
  assign rd_tag   = DATA_CACHE_READ_ADDRESS[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
  assign wr_idx   = DATA_CACHE_WRITE_ADDRESS[INDEX_WIDTH+1:2];
  assign wr_tag   = DATA_CACHE_WRITE_ADDRESS[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
  assign fill_idx = rd_addr_q[INDEX_WIDTH-1:0];
  assign fill_tag = rd_addr_q[WADDR_WIDTH-1:INDEX_WIDTH];

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign load_req  = DATA_CACHE_LOAD != DATA_CACHE_LOAD_NONE;
  assign store_req = DATA_CACHE_STORE != DATA_CACHE_STORE_NONE;

  // done_q marks the held store as already written, so the load half of a
  // combined request can proceed without re-issuing the store.
  assign start_store = (state_q == IDLE) && store_req && !done_q;
  assign start_load  = (state_q == IDLE) && !start_store && load_req && !rd_hit;
  assign cpu_ready   = !RST && (state_q == IDLE) && !start_store && !start_load;

  always_comb begin
    st_data = DATA_CACHE_WRITE_DATA;
    st_strb = '1;
    case (DATA_CACHE_STORE)
      DATA_CACHE_STORE_B: begin
        st_data = {(L2_BUS_WIDTH/8){DATA_CACHE_WRITE_DATA[7:0]}};
        st_strb = STRB_WIDTH'(1) << DATA_CACHE_WRITE_ADDRESS[1:0];
      end
      DATA_CACHE_STORE_H: begin
        st_data = {(L2_BUS_WIDTH/16){DATA_CACHE_WRITE_DATA[15:0]}};
        st_strb = DATA_CACHE_WRITE_ADDRESS[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  d_cache_load_align #(
    .DATA_WIDTH       (DATA_WIDTH),
    .D_CACHE_LW_WIDTH (D_CACHE_LW_WIDTH)
  ) u_load_align (
    .word      (data_q[rd_idx]),
    .byte_sel  (DATA_CACHE_READ_ADDRESS[1:0]),
    .load_type (DATA_CACHE_LOAD),
    .load_data (load_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_store)     state_d = WR_REQ;
        else if (start_load) state_d = RD_ADDR;
      end
      RD_ADDR: if (READ_ADDR_TO_L2_READY_DATA) state_d = RD_DATA;
      RD_DATA: if (DATA_FROM_L2_VALID_DATA)    state_d = IDLE;
      WR_REQ:  if (WRITE_TO_L2_READY_DATA)     state_d = WR_WAIT;
      WR_WAIT: if (WRITE_COMPLETE_DATA)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DATA_CACHE_READY           = cpu_ready;
    DATA_CACHE_READ_DATA       = '0;
    READ_ADDR_TO_L2_VALID_DATA = LOW;
    DATA_FROM_L2_READY_DATA    = LOW;
    WRITE_TO_L2_VALID_DATA     = LOW;
    WRITE_CONTROL_TO_L2_DATA   = LOW;
    if (cpu_ready && load_req) DATA_CACHE_READ_DATA = load_data;
    case (state_q)
      RD_ADDR: READ_ADDR_TO_L2_VALID_DATA = HIGH;
      RD_DATA: DATA_FROM_L2_READY_DATA    = HIGH;
      WR_REQ: begin
        WRITE_TO_L2_VALID_DATA   = HIGH;
        WRITE_CONTROL_TO_L2_DATA = HIGH;
      end
      default: ;
    endcase
  end

  assign READ_ADDR_TO_L2_DATA    = rd_addr_q;
  assign WRITE_ADDR_TO_L2_DATA   = wr_addr_q;
  assign DATA_TO_L2_DATA         = wr_data_q;
  assign WRITE_STROBE_TO_L2_DATA = wr_strb_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      done_q    <= LOW;
    end else begin
      if (start_store) begin
        wr_addr_q <= DATA_CACHE_WRITE_ADDRESS[ADDRESS_WIDTH-1:2];
        wr_data_q <= st_data;
        wr_strb_q <= st_strb;
        if (wr_hit) data_q[wr_idx] <= merge_bytes(data_q[wr_idx], st_data, st_strb);
      end
      if (start_load) rd_addr_q <= DATA_CACHE_READ_ADDRESS[ADDRESS_WIDTH-1:2];
      if (state_q == RD_DATA && DATA_FROM_L2_VALID_DATA) begin
        valid_q[fill_idx] <= HIGH;
        tag_q[fill_idx]   <= fill_tag;
        data_q[fill_idx]  <= DATA_FROM_L2_DATA;
      end
      if (state_q == WR_WAIT && WRITE_COMPLETE_DATA) done_q <= HIGH;
      else if (cpu_ready)                            done_q <= LOW;
    end
  end

endmodule

// File: tb/tb_data_cache_dm_wt.sv
// Bench for data_cache_dm_wt: an L2 memory model with programmable stalls,
// table-driven load-hit vectors and hand-written miss/store/reset sequences.
module tb_data_cache_dm_wt;

  localparam logic [2:0] LD_NONE = 3'b000, LD_BS = 3'b010, LD_BU = 3'b011,
                         LD_HS = 3'b100, LD_HU = 3'b101, LD_W = 3'b110;
  localparam logic [1:0] ST_NONE = 2'b00, ST_B = 2'b01, ST_H = 2'b10, ST_W = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_raddr, cpu_waddr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_load;
  logic [1:0]  cpu_store;
  logic        cpu_ready;
  logic        wr_ready, wr_valid, wr_ctrl, wr_complete;
  logic [29:0] wr_addr, rd_addr;
  logic [31:0] wr_data, fill_data;
  logic [3:0]  wr_strb;
  logic        rd_ready, rd_valid, fill_ready, fill_valid;

  always #5 clk = ~clk;

  data_cache_dm_wt dut (
    .CLK                        (clk),
    .RST                        (rst),
    .DATA_CACHE_READ_ADDRESS    (cpu_raddr),
    .DATA_CACHE_LOAD            (cpu_load),
    .DATA_CACHE_WRITE_ADDRESS   (cpu_waddr),
    .DATA_CACHE_WRITE_DATA      (cpu_wdata),
    .DATA_CACHE_STORE           (cpu_store),
    .DATA_CACHE_READY           (cpu_ready),
    .DATA_CACHE_READ_DATA       (cpu_rdata),
    .WRITE_TO_L2_READY_DATA     (wr_ready),
    .WRITE_TO_L2_VALID_DATA     (wr_valid),
    .WRITE_ADDR_TO_L2_DATA      (wr_addr),
    .DATA_TO_L2_DATA            (wr_data),
    .WRITE_STROBE_TO_L2_DATA    (wr_strb),
    .WRITE_CONTROL_TO_L2_DATA   (wr_ctrl),
    .WRITE_COMPLETE_DATA        (wr_complete),
    .READ_ADDR_TO_L2_READY_DATA (rd_ready),
    .READ_ADDR_TO_L2_VALID_DATA (rd_valid),
    .READ_ADDR_TO_L2_DATA       (rd_addr),
    .DATA_FROM_L2_READY_DATA    (fill_ready),
    .DATA_FROM_L2_VALID_DATA    (fill_valid),
    .DATA_FROM_L2_DATA          (fill_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // L2 model state
  logic [31:0] mem [logic [29:0]];
  int          rd_stall = 0, wr_stall = 0;
  int          rd_cnt = 0, wr_cnt = 0;
  logic        hold_fill = 1'b0;
  logic [29:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [3:0]  last_wr_strb;

  initial begin
    int          rd_wait, wr_wait;
    logic        wr_pend;
    logic [29:0] rd_seen, rd_last, wa_seen;
    logic [31:0] wd_seen, word;
    rd_wait = 0; wr_wait = 0; wr_pend = 1'b0;
    rd_seen = '0; rd_last = '0; wa_seen = '0; wd_seen = '0;
    wr_ready = 1'b0; wr_complete = 1'b0; rd_ready = 1'b0;
    fill_valid = 1'b0; fill_data = '0;
    forever begin
      @(negedge clk);
      rd_ready = 1'b0; fill_valid = 1'b0; wr_ready = 1'b0; wr_complete = 1'b0;
      if (rst) begin
        rd_wait = 0; wr_wait = 0; wr_pend = 1'b0;
      end else begin
        if (rd_valid) begin
          if (rd_wait == 0) rd_seen = rd_addr;
          else check("rd_addr_stable", {2'b00, rd_addr}, {2'b00, rd_seen});
          if (rd_wait >= rd_stall) begin
            rd_ready = 1'b1; rd_wait = 0; rd_cnt++; rd_last = rd_addr;
          end else rd_wait++;
        end
        if (fill_ready && !hold_fill) begin
          fill_valid = 1'b1;
          fill_data  = mem.exists(rd_last) ? mem[rd_last] : 32'h0;
        end
        if (wr_pend) begin
          wr_complete = 1'b1; wr_pend = 1'b0;
        end
        if (wr_valid) begin
          check("wr_control", {31'b0, wr_ctrl}, 32'd1);
          if (wr_wait == 0) begin
            wa_seen = wr_addr; wd_seen = wr_data;
          end else begin
            check("wr_addr_stable", {2'b00, wr_addr}, {2'b00, wa_seen});
            check("wr_data_stable", wr_data, wd_seen);
          end
          if (wr_wait >= wr_stall) begin
            wr_ready = 1'b1; wr_wait = 0; wr_cnt++; wr_pend = 1'b1;
            last_wr_addr = wr_addr; last_wr_data = wr_data; last_wr_strb = wr_strb;
            word = mem.exists(wr_addr) ? mem[wr_addr] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (wr_strb[b]) word[8*b +: 8] = wr_data[8*b +: 8];
            mem[wr_addr] = word;
          end else wr_wait++;
        end
      end
    end
  end

  logic [31:0] exp_q[$];

  // Drives one CPU request at a negedge and holds it until READY; the
  // expected read data is queued at issue and popped when READY appears.
  task automatic cpu_op(input string name, input logic [2:0] ld, input logic [31:0] ra,
                        input logic [1:0] st, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] want, output int cycles);
    logic [31:0] exp;
    @(negedge clk);
    cpu_load = ld; cpu_raddr = ra; cpu_store = st; cpu_waddr = wa; cpu_wdata = wd;
    exp_q.push_back(want);
    cycles = 0;
    #1;
    while (!cpu_ready && cycles < 100) begin
      @(negedge clk); #1; cycles++;
    end
    exp = exp_q.pop_front();
    if (!cpu_ready) check({name, "_timeout"}, 32'd0, 32'd1);
    else            check(name, cpu_rdata, exp);
  endtask

  typedef struct {
    logic [2:0]  ld;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cyc, base_rd, base_wr, n;
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
    cyc = 0; base_rd = 0; base_wr = 0; n = 0;
  end

  initial begin
    int cyc, base_rd, base_wr, n;
    vecs[0]  = '{LD_W,    32'h100, 32'hDEADBEEF};
    vecs[1]  = '{LD_BS,   32'h103, 32'hFFFFFFDE};
    vecs[2]  = '{LD_BU,   32'h103, 32'h000000DE};
    vecs[3]  = '{LD_HS,   32'h102, 32'hFFFFDEAD};
    vecs[4]  = '{LD_HU,   32'h102, 32'h0000DEAD};
    vecs[5]  = '{LD_BS,   32'h100, 32'hFFFFFFEF};
    vecs[6]  = '{LD_BU,   32'h101, 32'h000000BE};
    vecs[7]  = '{LD_HS,   32'h100, 32'hFFFFBEEF};
    vecs[8]  = '{LD_HS,   32'h103, 32'hFFFFDEAD};
    vecs[9]  = '{LD_W,    32'h102, 32'hDEADBEEF};
    vecs[10] = '{LD_NONE, 32'h100, 32'h00000000};

    mem[30'h40] = 32'hDEADBEEF;
    mem[30'h50] = 32'h13579BDF;

    rst = 1'b1;
    cpu_load = LD_NONE; cpu_store = ST_NONE;
    cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'b0, cpu_ready}, 32'd0);
    check("rst_l2_ctrl", {28'b0, rd_valid, fill_ready, wr_valid, wr_ctrl}, 32'd0);
    check("rst_wr_strb", {28'b0, wr_strb}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_ready", {31'b0, cpu_ready}, 32'd1);
    check("idle_rdata", cpu_rdata, 32'd0);

    // first miss, watching the address offered to L2
    base_rd = rd_cnt;
    cpu_op("miss_w_100", LD_W, 32'h100, ST_NONE, 32'h0, 32'h0, 32'hDEADBEEF, cyc);
    check("miss_cycles", cyc, 32'd3);
    check("miss_rd_addr", {2'b00, rd_addr}, 32'h40);
    check("miss_rd_cnt", rd_cnt - base_rd, 32'd1);

    base_rd = rd_cnt;
    for (int i = 0; i < 11; i++) begin
      cpu_op($sformatf("vec%0d", i), vecs[i].ld, vecs[i].ra, ST_NONE, 32'h0, 32'h0,
             vecs[i].exp, cyc);
      check($sformatf("vec%0d_cycles", i), cyc, 32'd0);
    end
    check("hits_no_l2_rd", rd_cnt - base_rd, 32'd0);

    base_wr = wr_cnt;
    cpu_op("st_b_101", LD_NONE, 32'h0, ST_B, 32'h101, 32'h5A, 32'h0, cyc);
    check("st_b_cycles", cyc, 32'd3);
    check("st_b_strb", {28'b0, last_wr_strb}, 32'h2);
    check("st_b_data", last_wr_data, 32'h5A5A5A5A);
    check("st_b_addr", {2'b00, last_wr_addr}, 32'h40);
    check("st_b_wr_cnt", wr_cnt - base_wr, 32'd1);
    cpu_op("ld_after_st_b", LD_W, 32'h100, ST_NONE, 32'h0, 32'h0, 32'hDEAD5AEF, cyc);
    check("ld_after_st_b_cycles", cyc, 32'd0);

    // store and load together: store first, the load then sees the merge
    base_wr = wr_cnt;
    cpu_op("st_h_ld_w", LD_W, 32'h100, ST_H, 32'h102, 32'hFFFF1234, 32'h12345AEF, cyc);
    check("st_h_cycles", cyc, 32'd3);
    check("st_h_strb", {28'b0, last_wr_strb}, 32'hC);
    check("st_h_data", last_wr_data, 32'h12341234);
    check("st_h_wr_cnt", wr_cnt - base_wr, 32'd1);

    // store miss with a stalling L2: no allocate, no duplicate write
    wr_stall = 5;
    base_wr = wr_cnt;
    cpu_op("st_w_200", LD_NONE, 32'h0, ST_W, 32'h200, 32'hCAFEF00D, 32'h0, cyc);
    check("st_w_cycles", cyc, 32'd8);
    check("st_w_strb", {28'b0, last_wr_strb}, 32'hF);
    check("st_w_addr", {2'b00, last_wr_addr}, 32'h80);
    check("st_w_wr_cnt", wr_cnt - base_wr, 32'd1);
    wr_stall = 0;

    rd_stall = 5;
    base_rd = rd_cnt;
    cpu_op("ld_200_miss", LD_W, 32'h200, ST_NONE, 32'h0, 32'h0, 32'hCAFEF00D, cyc);
    check("ld_200_cycles", cyc, 32'd8);
    check("ld_200_rd_cnt", rd_cnt - base_rd, 32'd1);
    rd_stall = 0;
    cpu_op("ld_200_hit", LD_W, 32'h200, ST_NONE, 32'h0, 32'h0, 32'hCAFEF00D, cyc);
    check("ld_200_hit_cycles", cyc, 32'd0);
    cpu_op("ld_100_evicted", LD_W, 32'h100, ST_NONE, 32'h0, 32'h0, 32'h12345AEF, cyc);
    check("ld_100_evicted_cycles", cyc, 32'd3);

    // reset while waiting for fill data
    hold_fill = 1'b1;
    @(negedge clk);
    cpu_load = LD_W; cpu_raddr = 32'h140; cpu_store = ST_NONE;
    n = 0;
    #1;
    while (!fill_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("reach_rd_data", {31'b0, fill_ready}, 32'd1);
    rst = 1'b1;
    cpu_load = LD_NONE;
    #1;
    check("ready_in_rst", {31'b0, cpu_ready}, 32'd0);
    @(negedge clk); #1;
    check("abort_l2_ctrl", {28'b0, rd_valid, fill_ready, wr_valid, wr_ctrl}, 32'd0);
    check("abort_rd_addr", {2'b00, rd_addr}, 32'd0);
    check("abort_wr_addr", {2'b00, wr_addr}, 32'd0);
    check("abort_wr_data", wr_data, 32'd0);
    rst = 1'b0;
    hold_fill = 1'b0;
    base_rd = rd_cnt;
    cpu_op("ld_140_after_rst", LD_W, 32'h140, ST_NONE, 32'h0, 32'h0, 32'h13579BDF, cyc);
    check("ld_140_cycles", cyc, 32'd3);
    check("ld_140_rd_cnt", rd_cnt - base_rd, 32'd1);
    cpu_op("ld_100_after_rst", LD_W, 32'h100, ST_NONE, 32'h0, 32'h0, 32'h12345AEF, cyc);
    check("ld_100_after_rst_cycles", cyc, 32'd3);

    @(negedge clk);
    cpu_load = LD_NONE; cpu_store = ST_NONE;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_cache_dm_wt.md
Name: data_cache_dm_wt

Overview:
- Parametrised, direct-mapped, write-through, no-write-allocate L1 data cache for the MEM stage.
- Supersedes the pass-through data cache.
- Serves byte, halfword and word loads and stores with sign/zero extension. Load hits return data in zero wait states.
- Misses and all stores go to L2 over valid/ready channels. DATA_CACHE_READY stalls the pipeline.

Parameters:
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, CPU data width; must equal L2_BUS_WIDTH
- L2_BUS_WIDTH, 32, L2 word width; one line = one word
- D_CACHE_LW_WIDTH, 3, load-type code width
- D_CACHE_SW_WIDTH, 2, store-type code width
- INDEX_WIDTH, 6, log2 of line count (64 lines); tag = ADDRESS_WIDTH-2-INDEX_WIDTH bits

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - CLK in 1 clock
  - RST in 1 synchronous active-high reset
- CPU side:
  - DATA_CACHE_READ_ADDRESS in ADDRESS_WIDTH load byte address
  - DATA_CACHE_LOAD in D_CACHE_LW_WIDTH load type
  - DATA_CACHE_WRITE_ADDRESS in ADDRESS_WIDTH store byte address
  - DATA_CACHE_WRITE_DATA in DATA_WIDTH store data, right-aligned
  - DATA_CACHE_STORE in D_CACHE_SW_WIDTH store type
  - DATA_CACHE_READY out 1 high = request accepted / data valid; low = stall
  - DATA_CACHE_READ_DATA out DATA_WIDTH extended load result
- L2 write channel:
  - WRITE_TO_L2_READY_DATA in 1 L2 accepts write
  - WRITE_TO_L2_VALID_DATA out 1 write request valid
  - WRITE_ADDR_TO_L2_DATA out ADDRESS_WIDTH-2 word address
  - DATA_TO_L2_DATA out L2_BUS_WIDTH lane-aligned write data
  - WRITE_STROBE_TO_L2_DATA out L2_BUS_WIDTH/8 byte enables
  - WRITE_CONTROL_TO_L2_DATA out 1 high while a write request is valid
  - WRITE_COMPLETE_DATA in 1 one-cycle pulse: L2 write done
- L2 read channel:
  - READ_ADDR_TO_L2_READY_DATA in 1 L2 accepts read address
  - READ_ADDR_TO_L2_VALID_DATA out 1 read address valid
  - READ_ADDR_TO_L2_DATA out ADDRESS_WIDTH-2 word address
  - DATA_FROM_L2_READY_DATA out 1 cache ready for fill data
  - DATA_FROM_L2_VALID_DATA in 1 fill data valid
  - DATA_FROM_L2_DATA in L2_BUS_WIDTH fill word

Behaviour:
- Storage: flop arrays valid[2^INDEX_WIDTH], tag[], data[], read asynchronously.
  - index = addr[INDEX_WIDTH+1:2]
  - tag = addr[ADDRESS_WIDTH-1:INDEX_WIDTH+2]
- Reset (RST high at posedge):
  - all valid bits cleared; FSM to IDLE
  - all L2 valid/ready/control outputs 0; address, data and strobe outputs 0
  - DATA_CACHE_READY is 0 while RST is high and 1 in IDLE after reset
  - RST mid-transaction aborts it; the line being filled is not validated
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_WAIT.
- IDLE, load hit:
  - DATA_CACHE_READ_DATA and READY=1 are combinational in the same cycle
  - no state change
- IDLE, load miss:
  - READY=0 combinationally; latch the word address; go to RD_ADDR
- RD_ADDR:
  - READ_ADDR_TO_L2_VALID_DATA=1 with a stable address until READ_ADDR_TO_L2_READY_DATA=1 at a posedge, then go to RD_DATA
- RD_DATA:
  - DATA_FROM_L2_READY_DATA=1
  - on DATA_FROM_L2_VALID_DATA=1, write data/tag, set valid, go to IDLE
  - the held request then hits (miss latency = L2 latency + 2 cycles minimum)
- IDLE, any store (STORE != NONE):
  - READY=0
  - if hit, merge the bytes into the line in that cycle; a miss does not allocate
  - latch address, lane-aligned data and strobe; go to WR_REQ
- Strobes and lane placement:
  - byte: strobe 1<<addr[1:0]; data replicated to all lanes
  - half: strobe 0011 or 1100 by addr[1]
  - word: strobe 1111
- WR_REQ:
  - WRITE_TO_L2_VALID_DATA=1 and WRITE_CONTROL_TO_L2_DATA=1 until WRITE_TO_L2_READY_DATA=1, then go to WR_WAIT
- WR_WAIT:
  - wait for WRITE_COMPLETE_DATA, then go to IDLE
  - in the following IDLE cycle READY=1 (store retired)
- Store completion handshake:
  - the CPU holds its request while READY=0
  - after completion the FSM holds a one-cycle done flag; it suppresses re-issue of the same held store and drives READY=1
- Load extension:
  - B_S/B_U select byte addr[1:0], sign/zero-extended
  - H_S/H_U select half addr[1], sign/zero-extended
  - W returns the full word
  - misalignment is ignored: addr bit 0 for halves and bits 1:0 for words are forced to 0
- LOAD_NONE with STORE_NONE: READ_DATA=0, READY=1.
- Simultaneous load and store requests: the store is serviced first, then the load; the load sees the stored bytes on a hit.
- All L2 request outputs are registered state outputs; no combinational path exists from L2 inputs to L2 outputs.

Decomposition:
- Package d_cache_pkg:
  - DATA_CACHE_LOAD_* codes (NONE 000, B_S 010, B_U 011, H_S 100, H_U 101, W 110)
  - DATA_CACHE_STORE_* codes (NONE 00, B 01, H 10, W 11)
  - FSM state encoding
  - HIGH/LOW
- One sub-module d_cache_load_align: combinational byte/half select and extension, reused by the future I/D unified path.

Test Plan:
- Reset, then LOAD_W addr 0x100 (miss) → READ_ADDR_TO_L2_DATA=0x40 valid until ready; L2 returns 0xDEADBEEF → next cycle READY=1, READ_DATA=0xDEADBEEF; a repeat load hits with zero L2 activity.
- Load B_S at 0x103 after the fill → 0xFFFFFFDE. B_U at 0x103 → 0x000000DE. H_S at 0x102 → 0xFFFFDEAD.
- STORE_B 0x5A at 0x101 (hit) → WRITE_STROBE=0010, DATA_TO_L2 lanes=0x5A5A5A5A. READY low until WRITE_COMPLETE. Subsequent LOAD_W 0x100 hit → 0xDEAD5AEF.
- STORE_W to 0x200 (miss) → L2 write issued. Subsequent LOAD_W 0x200 misses (no allocate).
- L2 holds READY low for 5 cycles in RD_ADDR and WR_REQ → valid and address stay stable, no duplicate request.
- RST asserted in RD_DATA before fill valid → returns to IDLE, outputs 0; LOAD_W to the same address misses again.
